// File: rtl/psg_write_seq.sv
// Buffered host-to-PSG write sequencer: FIFO of command bytes replayed on the D/nCE/nWE bus with READY handshake.
// Build option PSG_MUTE_ON_RESET_EN: after reset, write volume-off to all four channels before serving the FIFO.
module psg_write_seq #(
   parameter int FIFO_DEPTH    = 8,
   parameter int STROBE_CYCLES = 16,
   parameter int TIMEOUT       = 255
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [7:0]                         wr_data,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   output logic [7:0]                         D,
   output logic                               nCE,
   output logic                               nWE,
   input  logic                               READY,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               timeout_err,
   input  logic                               clr_err
);

   // state     | meaning
   // S_IDLE    | bus released; pop next byte (init byte first, if pending) into D
   // S_SETUP   | nCE low, nWE high, D settling for one cycle
   // S_STROBE  | nCE and nWE low; wait for READY low and the minimum strobe width
   // S_RELEASE | nCE and nWE high, D held for one cycle
   // S_WAIT_RDY| wait for READY to return high before the next byte

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_FW = $clog2(FIFO_DEPTH+1);
   localparam int CNT_MAX = (TIMEOUT > STROBE_CYCLES) ? TIMEOUT : STROBE_CYCLES;
   localparam int CNT_W  = $clog2(CNT_MAX+1);

   localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYCLES-1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_FW-1:0] DEPTH_C     = CNT_FW'(FIFO_DEPTH);
   localparam logic [CNT_FW-1:0] COUNT_ONE   = CNT_FW'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_RELEASE,
      S_WAIT_RDY
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                seen_low_q, seen_low_d;
   logic                seen_now;
   logic [7:0]          dout_q, dout_d;
   logic                nce_q, nce_d;
   logic                nwe_q, nwe_d;
   logic                err_q, err_d;
   logic                err_set;
   logic                busy_q, busy_d;
   logic                wr_ready_q, wr_ready_d;

   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [7:0]          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [CNT_FW-1:0]   count_q, count_d;
   logic                push;
   logic                pop;

   logic                init_active;
   logic                init_pend_d;
   logic [7:0]          init_byte;

`ifdef PSG_MUTE_ON_RESET_EN
   // init_q walks 0..3 over the four channel volume-off latches; 4 means done
   logic [2:0]          init_q, init_d;

   assign init_active = (init_q != 3'd4);
   assign init_byte   = {1'b1, init_q[1:0], 5'h1F};

   always_comb begin
      init_d = init_q;
      if (state_q == S_IDLE && init_active) begin
         init_d = init_q + 3'd1;
      end
   end

   assign init_pend_d = (init_d != 3'd4);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         init_q <= '0;
      end else begin
         init_q <= init_d;
      end
   end
`else
   assign init_active = 1'b0;
   assign init_byte   = 8'h00;
   assign init_pend_d = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      seen_low_d = seen_low_q;
      seen_now   = seen_low_q | ~READY;
      dout_d     = dout_q;
      err_set    = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (init_active) begin
               dout_d  = init_byte;
               state_d = S_SETUP;
            end else if (count_q != '0) begin
               dout_d  = mem_q[rptr_q];
               pop     = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d      = '0;
            seen_low_d = 1'b0;
            state_d    = S_STROBE;
         end
         S_STROBE: begin
            seen_low_d = seen_now;
            if (seen_now && cnt_q >= STROBE_LAST) begin
               state_d = S_RELEASE;
            end else if (!seen_now && cnt_q >= TIMEOUT_C) begin
               // no acknowledge: the byte is abandoned, not retried
               err_set = 1'b1;
               state_d = S_RELEASE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RELEASE: begin
            cnt_d   = '0;
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (READY) begin
               state_d = S_IDLE;
            end else if (cnt_q >= TIMEOUT_C) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // a push is judged against the registered count, so a full FIFO refuses it even on a pop cycle
   always_comb begin
      push   = wr_valid && wr_ready_q;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         mem_d[wptr_q] = wr_data;
         wptr_d        = wptr_q + PTR_ONE;
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wr_ready_d = (count_d != DEPTH_C);
      busy_d     = (state_d != S_IDLE) || (count_d != '0) || init_pend_d;
      nce_d      = !((state_d == S_SETUP) || (state_d == S_STROBE));
      nwe_d      = (state_d != S_STROBE);
      err_d      = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (clr_err) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         seen_low_q <= 1'b0;
         dout_q     <= 8'h00;
         nce_q      <= 1'b1;
         nwe_q      <= 1'b1;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         wr_ready_q <= 1'b1;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         seen_low_q <= seen_low_d;
         dout_q     <= dout_d;
         nce_q      <= nce_d;
         nwe_q      <= nwe_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         wr_ready_q <= wr_ready_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign D           = dout_q;
   assign nCE         = nce_q;
   assign nWE         = nwe_q;
   assign wr_ready    = wr_ready_q;
   assign busy        = busy_q;
   assign fifo_count  = count_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_psg_write_seq.sv
// Bench for psg_write_seq: expected-write queue plus a behavioural PSG READY responder.
module tb_psg_write_seq;

   logic       CLK;
   logic       RST;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] D;
   logic       nCE;
   logic       nWE;
   logic       READY;
   logic       busy;
   logic [3:0] fifo_count;
   logic       timeout_err;
   logic       clr_err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      int         len;
   } wr_t;

   wr_t exp_q[$];

   // PSG responder knobs
   int ready_lo_dly = 2;
   int ready_hi_dly = 3;
   bit ack_en       = 1'b1;
   int lo_n = 0;
   int hi_n = 0;
   bit pend = 1'b0;

   int   lo_len   = 0;
   logic prev_nwe = 1'b1;

   psg_write_seq dut (
      .CLK         (CLK),
      .RST         (RST),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .D           (D),
      .nCE         (nCE),
      .nWE         (nWE),
      .READY       (READY),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // READY goes low ready_lo_dly cycles into the strobe, returns high ready_hi_dly cycles after nWE rises
   initial begin
      READY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         if (RST) begin
            pend = 1'b0;
            lo_n = 0;
            hi_n = 0;
         end else if (!nWE) begin
            lo_n++;
            hi_n = 0;
            if (ack_en && lo_n >= ready_lo_dly) pend = 1'b1;
         end else begin
            hi_n++;
            lo_n = 0;
            if (hi_n >= ready_hi_dly) pend = 1'b0;
         end
         READY = !pend;
      end
   end

   // Bus compare: every chip-enabled cycle must carry the head expected byte; strobe width checked at nWE rise
   always @(negedge CLK) begin
      if (RST) begin
         lo_len   = 0;
         prev_nwe = 1'b1;
      end else begin
         check("nwe_inside_nce", 32'(!nWE && nCE), 0);
         if (!nCE) begin
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("d_stable", D, exp_q[0].data);
         end
         if (!nWE) begin
            lo_len++;
         end else if (!prev_nwe) begin
            if (exp_q.size() != 0) begin
               check("d_release", D, exp_q[0].data);
               check("strobe_len", lo_len, exp_q[0].len);
               void'(exp_q.pop_front());
            end
            lo_len = 0;
         end
         prev_nwe = nWE;
      end
   end

   task automatic add_init();
`ifdef PSG_MUTE_ON_RESET_EN
      exp_q.push_back('{8'h9F, 16});
      exp_q.push_back('{8'hBF, 16});
      exp_q.push_back('{8'hDF, 16});
      exp_q.push_back('{8'hFF, 16});
`endif
   endtask

   task automatic do_reset();
      RST = 1'b1;
      #1;
      check("rst_nwe", nWE, 1);
      check("rst_nce", nCE, 1);
      check("rst_d", D, 8'h00);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_timeout_err", timeout_err, 0);
      repeat (2) @(posedge CLK);
      #1;
      exp_q.delete();
      RST = 1'b0;
      add_init();
   endtask

   task automatic push(input logic [7:0] b, input bit acc, input int len);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge CLK);
      check("push_wr_ready", wr_ready, acc);
      if (acc) exp_q.push_back('{b, len});
      @(posedge CLK);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int n);
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < n) begin
         @(posedge CLK);
         #1;
         k++;
      end
      check(nm, 32'(k < n), 1);
   endtask

   task automatic wait_nwe(input logic lvl, input int n, input string nm);
      int k = 0;
      while (nWE !== lvl && k < n) begin
         @(posedge CLK);
         #1;
         k++;
      end
      check(nm, 32'(k < n), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST      = 1'b1;
      wr_data  = 8'h00;
      wr_valid = 1'b0;
      clr_err  = 1'b0;
      do_reset();
      wait_idle("init_drain", 400);

      // single byte: latency and strobe width
      push(8'h8A, 1'b1, 16);
      check("t1_idle_nce", nCE, 1);
      check("t1_count1", fifo_count, 1);
      check("t1_busy", busy, 1);
      @(posedge CLK);
      #1;
      check("t1_setup_nce", nCE, 0);
      check("t1_setup_nwe", nWE, 1);
      check("t1_setup_d", D, 8'h8A);
      check("t1_count0", fifo_count, 0);
      @(posedge CLK);
      #1;
      check("t1_strobe_nwe", nWE, 0);
      wait_idle("t1_done", 100);
      check("t1_busy_low", busy, 0);
      check("t1_no_err", timeout_err, 0);

      // latch byte followed by data byte
      push(8'h85, 1'b1, 16);
      push(8'h12, 1'b1, 16);
      wait_idle("t2_done", 200);
      check("t2_count", fifo_count, 0);

      // fill the FIFO while the PSG holds READY low
      ready_hi_dly = 80;
      push(8'h11, 1'b1, 16);
      wait_nwe(1'b0, 10, "t3_strobe_start");
      wait_nwe(1'b1, 40, "t3_strobe_end");
      for (int i = 0; i < 9; i++) begin
         push(8'(8'hA0 + i), (i < 8), 16);
      end
      check("t3_count_full", fifo_count, 8);
      check("t3_not_ready", wr_ready, 0);
      check("t3_busy", busy, 1);
      ready_hi_dly = 3;
      wait_idle("t3_drain", 2000);
      check("t3_count_empty", fifo_count, 0);
      check("t3_ready_again", wr_ready, 1);

      // PSG never acknowledges: strobe held TIMEOUT+1 cycles, then sticky error
      ack_en = 1'b0;
      push(8'h90, 1'b1, 256);
      wait_idle("t4_timeout_done", 400);
      check("t4_err_set", timeout_err, 1);
      ack_en = 1'b1;
      push(8'h33, 1'b1, 16);
      wait_idle("t4_next_done", 100);
      check("t4_err_sticky", timeout_err, 1);
      clr_err = 1'b1;
      @(posedge CLK);
      #1;
      clr_err = 1'b0;
      check("t4_err_cleared", timeout_err, 0);

      // reset in the middle of a strobe with three bytes queued
      push(8'h41, 1'b1, 16);
      push(8'h42, 1'b1, 16);
      push(8'h43, 1'b1, 16);
      push(8'h44, 1'b1, 16);
      check("t5_queued", fifo_count, 3);
      wait_nwe(1'b0, 10, "t5_in_strobe");
      repeat (4) @(posedge CLK);
      #1;
      do_reset();
      wait_idle("t5_after_reset", 400);
      repeat (40) @(posedge CLK);
      #1;
      check("t5_quiet_nce", nCE, 1);
      check("t5_count", fifo_count, 0);

      // byte pending across reset release (mute sequence first when built with it)
      wr_data  = 8'h81;
      wr_valid = 1'b1;
      do_reset();
      exp_q.push_back('{8'h81, 16});
      @(posedge CLK);
      #1;
      wr_valid = 1'b0;
      check("t6_count", fifo_count, 1);
      check("t6_busy", busy, 1);
      wait_idle("t6_done", 600);
      check("t6_count_end", fifo_count, 0);
      check("t6_no_err", timeout_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/psg_write_seq.md
Name: psg_write_seq

Overview:
- Upstream host-side write sequencer for the SN76489-compatible PSG core.
- Accepts register bytes from the system bus through a valid/ready port and buffers them in a small FIFO.
- Replays each byte to the PSG chip interface (D, nCE, nWE) with timing that satisfies the PSG's divided-clock sampling.
- Waits for the PSG READY handshake before issuing the next byte, and flags stalled writes.

Parameters:
- FIFO_DEPTH, 8: number of buffered bytes; must be a power of 2, minimum 2.
- STROBE_CYCLES, 16: minimum number of CLK cycles that nWE is held low (one full PSG divider period).
- TIMEOUT, 255: maximum number of CLK cycles to wait in STROBE for READY to go low, and in WAIT_RDY for READY to return high. Range 1..1023.

Ports:
- CLK  in  1  system clock, shared with the PSG core.
- RST  in  1  asynchronous reset, active-high.
- wr_data  in  8  PSG command byte (latch or data format).
- wr_valid  in  1  wr_data is valid this cycle.
- wr_ready  out  1  FIFO not full; a byte is accepted when wr_valid && wr_ready.
- D  out  8  PSG data bus.
- nCE  out  1  PSG chip enable, active-low.
- nWE  out  1  PSG write enable, active-low.
- READY  in  1  PSG ready; low while the PSG is absorbing a write.
- busy  out  1  high whenever state != IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of bytes currently buffered.
- timeout_err  out  1  sticky flag; set on a handshake timeout.
- clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset values (asynchronous, taking effect immediately): nCE=1, nWE=1, D=0x00, wr_ready=1, busy=0, fifo_count=0, timeout_err=0, state=IDLE. The FIFO is flushed.
- All outputs are registered. wr_ready is derived from the registered count (count != FIFO_DEPTH).
- FIFO ordering is first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle: count is unchanged and both operations take effect.
- Push while full is ignored, even if a pop occurs in that same cycle.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head into D and go to SETUP. nCE=1, nWE=1.
  - SETUP (1 cycle): nCE=0, nWE=1, D stable. Go to STROBE and clear the cycle counter.
  - STROBE: nCE=0, nWE=0. The counter increments every cycle. A seen_low flag is set once READY==0 is sampled.
    - Exit to RELEASE when seen_low && counter >= STROBE_CYCLES-1.
    - If counter reaches TIMEOUT with seen_low==0: set timeout_err and go to RELEASE (the byte is dropped and not retried).
  - RELEASE (1 cycle): nWE=1, nCE=1, D held. Go to WAIT_RDY and clear the counter.
  - WAIT_RDY: go to IDLE when READY==1. If the counter reaches TIMEOUT first: set timeout_err and go to IDLE.
- Latency: from a byte accepted into an empty FIFO with the sequencer in IDLE, nCE falls 2 cycles later (push cycle, then IDLE pop, then SETUP).
- Per-byte bus occupancy: at least 1 + STROBE_CYCLES + 1 + 1 cycles.
- D changes only in IDLE on a pop, so it is stable throughout SETUP, STROBE and RELEASE.
- timeout_err: clr_err clears it in the cycle after assertion. If set and clear coincide, set wins.
- Reset mid-transfer: the in-flight byte and all buffered bytes are lost. nWE and nCE go high asynchronously.

Optional Feature:
- Macro: PSG_MUTE_ON_RESET_EN.
- Defined: after reset deassertion, the sequencer writes 0x9F, 0xBF, 0xDF, 0xFF (all four channels at volume off) through the normal SETUP/STROBE/RELEASE/WAIT_RDY sequence before popping the FIFO.
  - The FIFO still accepts pushes during this init sequence.
  - busy is high throughout the init sequence.
- Not defined: the sequencer starts in IDLE and drives no writes until the FIFO is pushed.

Test Plan:
- Push 0x8A with READY modelled low 2 cycles after nWE falls, then high 3 cycles after nWE rises -> D=0x8A; nCE low for 1+16+... cycles; nWE low for exactly 16 cycles; busy drops after READY returns high; timeout_err=0.
- Push 9 bytes back-to-back with FIFO_DEPTH=8 while the sequencer is stalled -> wr_ready drops after 8 bytes are accepted; the 9th byte is dropped; fifo_count=8; the 8 bytes emerge in push order.
- Hold READY=1 permanently (model never acknowledges), push 0x90 -> nWE held low for 256 cycles; timeout_err=1; the sequencer returns to IDLE; the next byte proceeds. clr_err -> timeout_err=0 next cycle.
- Push 0x85, 0x12 with a compliant READY model -> PSG receives the latch byte then the data byte; D is stable across each strobe window; no overlap of the nCE low windows.
- Assert RST during STROBE with 3 bytes queued -> nWE=1 and nCE=1 immediately; fifo_count=0; no further strobes after release.
- With PSG_MUTE_ON_RESET_EN defined, release reset with a pending push of 0x81 -> strobes occur in the order 0x9F, 0xBF, 0xDF, 0xFF, 0x81.
